// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters decoded into registered
// hsync/vsync/de, active pixel coordinates and a frame-start strobe.
module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int X_W      = 12,
  parameter int Y_W      = 11
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           en,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One spare bit of headroom so sync-end boundaries never alias to zero.
  localparam int H_CW = $clog2(H_TOTAL + 1);
  localparam int V_CW = $clog2(V_TOTAL + 1);

  localparam logic [H_CW-1:0] H_LAST     = H_CW'(H_TOTAL - 1);
  localparam logic [H_CW-1:0] H_ACT_END  = H_CW'(H_ACTIVE);
  localparam logic [H_CW-1:0] H_SYNC_BEG = H_CW'(H_ACTIVE + H_FP);
  localparam logic [H_CW-1:0] H_SYNC_END = H_CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_CW-1:0] V_LAST     = V_CW'(V_TOTAL - 1);
  localparam logic [V_CW-1:0] V_ACT_END  = V_CW'(V_ACTIVE);
  localparam logic [V_CW-1:0] V_SYNC_BEG = V_CW'(V_ACTIVE + V_FP);
  localparam logic [V_CW-1:0] V_SYNC_END = V_CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [H_CW-1:0] h_cnt;
  logic [V_CW-1:0] v_cnt;
  logic            h_wrap;
  logic            v_wrap;
  logic            de_c;
  logic            hs_c;
  logic            vs_c;

  always_comb begin
    h_wrap = (h_cnt >= H_LAST);
    v_wrap = (v_cnt >= V_LAST);
    de_c   = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    hs_c   = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    vs_c   = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
  end

  // Dropping en parks the raster at the origin so the next enabled edge
  // emits the first active pixel together with frame_start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else if (!en) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
      hsync       <= hs_c ? HS_POL : ~HS_POL;
      vsync       <= vs_c ? VS_POL : ~VS_POL;
      de          <= de_c;
      x           <= de_c ? X_W'(h_cnt) : '0;
      y           <= de_c ? Y_W'(v_cnt) : '0;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule
